// File: rtl/nonogram_sequencer.sv
// nonogram_sequencer: fetches 2*GRID_N clue words from the registry into a local buffer,
// streams them to the solver, starts the translator and latches the solved grid.
// Adds solve timeout, fail reporting, abort and buffered clue readback.
// Optional build macro: CLUE_CHECK_EN enables per-word clue feasibility checking in FETCH.
`timescale 1ns/1ps
module nonogram_sequencer #(
    parameter int unsigned  GRID_N      = 10,
    parameter int unsigned  SLOT_W      = 4,
    parameter int unsigned  SLOTS       = 5,
    parameter int unsigned  TIMEOUT_CYC = 1048576,
    localparam int unsigned CLUE_W      = SLOT_W * SLOTS,
    localparam int unsigned IDX_W       = $clog2(2 * GRID_N)
) (
    input  logic                      clk_in,
    input  logic                      reset_n_in,
    input  logic                      start_in,
    input  logic                      abort_in,
    input  logic                      readback_in,
    input  logic [15:0]               puzzle_addr_in,
    output logic                      reg_req_out,
    output logic [15:0]               reg_addr_out,
    input  logic                      reg_valid_in,
    input  logic [CLUE_W-1:0]         reg_data_in,
    input  logic                      reg_last_in,
    output logic                      slv_valid_out,
    input  logic                      slv_ready_in,
    output logic [IDX_W-1:0]          slv_index_out,
    output logic [CLUE_W-1:0]         slv_data_out,
    input  logic                      slv_done_in,
    input  logic                      slv_fail_in,
    output logic                      tr_start_out,
    input  logic                      tr_done_in,
    input  logic [GRID_N*GRID_N-1:0]  tr_grid_in,
    output logic [GRID_N*GRID_N-1:0]  grid_out,
    output logic                      busy_out,
    output logic                      done_out,
    output logic                      error_out,
    output logic [1:0]                err_code_out,
    output logic                      rb_valid_out,
    output logic [CLUE_W-1:0]         rb_data_out,
    output logic                      rb_done_out
);
    localparam int unsigned WORDS  = 2 * GRID_N;
    localparam int unsigned CNT_W  = $clog2(WORDS + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned GRID_W = GRID_N * GRID_N;
    localparam int unsigned SUM_W  = SLOT_W + 4;

    localparam logic [1:0] ERR_FETCH   = 2'd1;
    localparam logic [1:0] ERR_SOLVER  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_STREAM, S_SOLVE, S_TRANSLATE, S_READBACK
    } state_e;

    state_e              state_q, state_d;
    logic                start_prev_q, rb_prev_q;
    logic [15:0]         addr_q, addr_d;
    logic                req_q, req_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d, idx_nx_c;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                bufv_q, bufv_d;
    logic                chk_bad_q, chk_bad_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [1:0]          code_q, code_d;
    logic [GRID_W-1:0]   grid_q, grid_d;
    logic                slv_valid_q, slv_valid_d;
    logic [CLUE_W-1:0]   slv_data_q, slv_data_d;
    logic                tr_start_q, tr_start_d;
    logic                rb_valid_q, rb_valid_d;
    logic [CLUE_W-1:0]   rb_data_q, rb_data_d;
    logic                rb_done_q, rb_done_d;
    logic                busy_q, busy_d;
    logic [CLUE_W-1:0]   clue_buf_q [WORDS];
    logic                buf_we_c;
    logic [IDX_W-1:0]    buf_wa_c;
    logic                start_edge_c, rb_edge_c, word_bad_c;

    assign start_edge_c = start_in && !start_prev_q;
    assign rb_edge_c    = readback_in && !rb_prev_q;
    assign idx_nx_c     = idx_q + IDX_W'(1);

`ifdef CLUE_CHECK_EN
    logic [SUM_W-1:0]  sum_c, nz_c;
    logic [SLOT_W-1:0] slot_c;

    // Minimum line length a clue word needs: runs plus one gap between each pair.
    always_comb begin
        sum_c  = '0;
        nz_c   = '0;
        slot_c = '0;
        for (int i = 0; i < int'(SLOTS); i++) begin
            slot_c = reg_data_in[i*SLOT_W +: SLOT_W];
            if (slot_c != '0) begin
                sum_c = sum_c + SUM_W'(slot_c);
                nz_c  = nz_c + SUM_W'(1);
            end
        end
        word_bad_c = (nz_c != '0) && ((sum_c + nz_c - SUM_W'(1)) > SUM_W'(GRID_N));
    end
`else
    assign word_bad_c = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b0;
            rb_prev_q    <= 1'b0;
            addr_q       <= '0;
            req_q        <= 1'b0;
            cnt_q        <= '0;
            idx_q        <= '0;
            tmo_q        <= '0;
            bufv_q       <= 1'b0;
            chk_bad_q    <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            code_q       <= '0;
            grid_q       <= '0;
            slv_valid_q  <= 1'b0;
            slv_data_q   <= '0;
            tr_start_q   <= 1'b0;
            rb_valid_q   <= 1'b0;
            rb_data_q    <= '0;
            rb_done_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_in;
            rb_prev_q    <= readback_in;
            addr_q       <= addr_d;
            req_q        <= req_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            tmo_q        <= tmo_d;
            bufv_q       <= bufv_d;
            chk_bad_q    <= chk_bad_d;
            done_q       <= done_d;
            err_q        <= err_d;
            code_q       <= code_d;
            grid_q       <= grid_d;
            slv_valid_q  <= slv_valid_d;
            slv_data_q   <= slv_data_d;
            tr_start_q   <= tr_start_d;
            rb_valid_q   <= rb_valid_d;
            rb_data_q    <= rb_data_d;
            rb_done_q    <= rb_done_d;
            busy_q       <= busy_d;
        end
    end

    // Clue buffer; contents are only meaningful while bufv_q is set.
    always_ff @(posedge clk_in) begin
        if (buf_we_c) clue_buf_q[buf_wa_c] <= reg_data_in;
    end

    // Next-state and output logic; abort overrides everything at the end.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        req_d       = 1'b0;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        bufv_d      = bufv_q;
        chk_bad_d   = chk_bad_q;
        done_d      = done_q;
        err_d       = err_q;
        code_d      = code_q;
        grid_d      = grid_q;
        slv_valid_d = slv_valid_q;
        slv_data_d  = slv_data_q;
        tr_start_d  = 1'b0;
        rb_valid_d  = rb_valid_q;
        rb_data_d   = rb_data_q;
        rb_done_d   = 1'b0;
        buf_we_c    = 1'b0;
        buf_wa_c    = IDX_W'(cnt_q);

        case (state_q)
            S_IDLE: begin
                if (start_edge_c) begin
                    addr_d    = puzzle_addr_in;
                    req_d     = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    code_d    = '0;
                    bufv_d    = 1'b0;
                    cnt_d     = '0;
                    chk_bad_d = 1'b0;
                    state_d   = S_FETCH;
                end else if (rb_edge_c && bufv_q) begin
                    idx_d      = '0;
                    rb_valid_d = 1'b1;
                    rb_data_d  = clue_buf_q[0];
                    state_d    = S_READBACK;
                end
            end
            S_FETCH: begin
                if (reg_valid_in) begin
                    // Words past the buffer end are dropped; cnt saturates so the fetch fails.
                    if (cnt_q < CNT_W'(WORDS)) begin
                        buf_we_c  = 1'b1;
                        cnt_d     = cnt_q + CNT_W'(1);
                        chk_bad_d = chk_bad_q | word_bad_c;
                    end
                    if (reg_last_in) begin
                        if (cnt_q == CNT_W'(WORDS - 1) && !chk_bad_q && !word_bad_c) begin
                            bufv_d      = 1'b1;
                            idx_d       = '0;
                            slv_valid_d = 1'b1;
                            slv_data_d  = clue_buf_q[0];
                            state_d     = S_STREAM;
                        end else begin
                            err_d   = 1'b1;
                            code_d  = ERR_FETCH;
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_STREAM: begin
                if (slv_ready_in) begin
                    if (idx_q == IDX_W'(WORDS - 1)) begin
                        slv_valid_d = 1'b0;
                        tmo_d       = '0;
                        state_d     = S_SOLVE;
                    end else begin
                        idx_d      = idx_nx_c;
                        slv_data_d = clue_buf_q[idx_nx_c];
                    end
                end
            end
            S_SOLVE: begin
                if (slv_fail_in) begin
                    err_d   = 1'b1;
                    code_d  = ERR_SOLVER;
                    state_d = S_IDLE;
                end else if (slv_done_in) begin
                    tr_start_d = 1'b1;
                    state_d    = S_TRANSLATE;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_TRANSLATE: begin
                if (tr_done_in) begin
                    grid_d  = tr_grid_in;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_READBACK: begin
                if (idx_q == IDX_W'(WORDS - 1)) begin
                    rb_valid_d = 1'b0;
                    rb_done_d  = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    idx_d     = idx_nx_c;
                    rb_data_d = clue_buf_q[idx_nx_c];
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_in) begin
            state_d     = S_IDLE;
            addr_d      = addr_q;
            req_d       = 1'b0;
            bufv_d      = bufv_q;
            done_d      = 1'b0;
            err_d       = err_q;
            code_d      = code_q;
            grid_d      = grid_q;
            slv_valid_d = 1'b0;
            tr_start_d  = 1'b0;
            rb_valid_d  = 1'b0;
            rb_done_d   = 1'b0;
            buf_we_c    = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign reg_req_out   = req_q;
    assign reg_addr_out  = addr_q;
    assign slv_valid_out = slv_valid_q;
    assign slv_index_out = idx_q;
    assign slv_data_out  = slv_data_q;
    assign tr_start_out  = tr_start_q;
    assign grid_out      = grid_q;
    assign busy_out      = busy_q;
    assign done_out      = done_q;
    assign error_out     = err_q;
    assign err_code_out  = code_q;
    assign rb_valid_out  = rb_valid_q;
    assign rb_data_out   = rb_data_q;
    assign rb_done_out   = rb_done_q;

endmodule
